seg7_scan_ctrl: RTL and testbench

//  Bus-configurable scan scheduler for a multiplexed 7-segment display.

---
 rtl/seg7_scan_ctrl_pkg.sv | 31 +++
 rtl/seg7_scan_ctrl_tick.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan scheduler: register offsets,
// CTRL bit positions, slot length and the scan FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package seg7_scan_ctrl_pkg;

  // Word offsets from BASE.
  localparam logic [1:0] SEG7_PRESCALE = 2'd0;
  localparam logic [1:0] SEG7_BRIGHT   = 2'd1;
  localparam logic [1:0] SEG7_MASK     = 2'd2;
  localparam logic [1:0] SEG7_CTRL     = 2'd3;

  // CTRL register bit positions.
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_BLANK_BIT = 1;

  // A slot is 16 ticks; sctr runs 0..15 within it.
  localparam logic [3:0] SLOT_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } scan_state_t;

  // Width of the digit index: at least one bit.
  function automatic int unsigned digit_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_tick.sv
// Prescaler: free-running counter producing a one-clock tick every period+1 clocks.
// Latency: tick is combinational from the counter; a shorter period applies at once.
// Backpressure: none; clr holds the counter at zero and suppresses tick.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clr           hold counter at zero (scan idle)
//   period[15:0]  terminal count; 0 gives a tick every clock
//   tick          1 when the counter has reached period
module seg7_scan_ctrl_tick (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        tick
);

  logic [15:0] r_pctr;
  logic        w_wrap;

  // >= rather than == so that lowering period below the current count
  // wraps immediately instead of running the counter round 64k.
  assign w_wrap = (r_pctr >= period);
  assign tick   = w_wrap & ~clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pctr <= '0;
    end else if (clr || w_wrap) begin
      r_pctr <= '0;
    end else begin
      r_pctr <= r_pctr + 16'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-configurable scan scheduler for a multiplexed 7-segment display.
// Latency: register write visible next clock, read data one clock after the
// request; anodes registered. Backpressure: none, bus always accepts.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable, rw, addr, data  word bus (rw=1 write); regs at BASE..BASE+3
//   rdata                 registered read data, zero-extended
//   an[NDIGITS-1:0]       active-low anode enables, at most one low
//   digit[DW-1:0]         current slot index
//   frame                 one-clock pulse when digit wraps to 0
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned BASE    = 16,
  parameter int unsigned NDIGITS = 4,
  parameter logic [15:0] PRE_RST = 16'h00FF,
  localparam int unsigned DW     = digit_width(NDIGITS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               rw,
  input  logic [31:0]        addr,
  input  logic [31:0]        data,
  output logic [31:0]        rdata,
  output logic [NDIGITS-1:0] an,
  output logic [DW-1:0]      digit,
  output logic               frame
);

  localparam logic [DW-1:0] DIG_LAST = DW'(NDIGITS - 1);
  localparam logic [DW-1:0] DIG_ONE  = DW'(1);

  // ---------------- register file and bus ----------------
  logic [15:0]        r_prescale, w_prescale_nx;
  logic [3:0]         r_bright,   w_bright_nx;
  logic [NDIGITS-1:0] r_mask,     w_mask_nx;
  logic [1:0]         r_ctrl,     w_ctrl_nx;
  logic [31:0]        r_rdata,    w_rd_val;

  logic [31:0] w_off;
  logic [1:0]  w_idx;
  logic        w_in_range;
  logic        w_wr;
  logic        w_rd;
  logic        w_unused;

  // Unsigned subtract: addresses below BASE wrap to huge offsets and fall out of range.
  assign w_off      = addr - 32'(BASE);
  assign w_in_range = (w_off < 32'd4);
  assign w_idx      = w_off[1:0];
  assign w_wr       = enable & rw & w_in_range;
  assign w_rd       = enable & ~rw;
  assign w_unused   = ^data[31:16];

  always_comb begin
    w_prescale_nx = r_prescale;
    w_bright_nx   = r_bright;
    w_mask_nx     = r_mask;
    w_ctrl_nx     = r_ctrl;
    if (w_wr) begin
      case (w_idx)
        SEG7_PRESCALE: w_prescale_nx = data[15:0];
        SEG7_BRIGHT:   w_bright_nx   = data[3:0];
        SEG7_MASK:     w_mask_nx     = data[NDIGITS-1:0];
        SEG7_CTRL:     w_ctrl_nx     = data[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_in_range) begin
      case (w_idx)
        SEG7_PRESCALE: w_rd_val[15:0]        = r_prescale;
        SEG7_BRIGHT:   w_rd_val[3:0]         = r_bright;
        SEG7_MASK:     w_rd_val[NDIGITS-1:0] = r_mask;
        SEG7_CTRL:     w_rd_val[1:0]         = r_ctrl;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= PRE_RST;
      r_bright   <= 4'hF;
      r_mask     <= '1;
      r_ctrl     <= 2'b01;
      r_rdata    <= '0;
    end else begin
      r_prescale <= w_prescale_nx;
      r_bright   <= w_bright_nx;
      r_mask     <= w_mask_nx;
      r_ctrl     <= w_ctrl_nx;
      if (w_rd) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  assign rdata = r_rdata;

  // ---------------- prescaler ----------------
  scan_state_t r_state, w_state_nx;
  logic        w_tick;
  logic        w_tick_clr;

  assign w_tick_clr = (r_state == ST_IDLE);

  seg7_scan_ctrl_tick u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_tick_clr),
    .period  (r_prescale),
    .tick    (w_tick)
  );

  // ---------------- scan FSM ----------------
  logic [3:0]         r_sctr,   w_sctr_nx;
  logic [3:0]         r_blat,   w_blat_nx;
  logic [DW-1:0]      r_digit,  w_digit_nx;
  logic               r_frame,  w_frame_nx;
  logic [NDIGITS-1:0] r_an,     w_an_nx;
  logic               w_run;
  logic               w_slot_end;

  assign w_run = r_ctrl[CTRL_RUN_BIT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_GUARD;
      r_sctr  <= '0;
      r_blat  <= 4'hF;
      r_digit <= '0;
      r_frame <= 1'b0;
      r_an    <= '1;
    end else begin
      r_state <= w_state_nx;
      r_sctr  <= w_sctr_nx;
      r_blat  <= w_blat_nx;
      r_digit <= w_digit_nx;
      r_frame <= w_frame_nx;
      r_an    <= w_an_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sctr_nx  = r_sctr;
    w_blat_nx  = r_blat;
    w_digit_nx = r_digit;
    w_frame_nx = 1'b0;
    w_slot_end = 1'b0;
    if (!w_run) begin
      w_state_nx = ST_IDLE;
      w_sctr_nx  = '0;
      w_digit_nx = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_GUARD;
          w_sctr_nx  = '0;
          w_digit_nx = '0;
        end
        ST_GUARD: begin
          if (w_tick) begin
            // Brightness is frozen here so a mid-slot write cannot stretch this slot.
            w_sctr_nx  = 4'd1;
            w_blat_nx  = r_bright;
            w_state_nx = (r_bright != 4'd0) ? ST_ON : ST_OFF;
          end
        end
        ST_ON: begin
          if (w_tick) begin
            w_sctr_nx = r_sctr + 4'd1;
            // At full brightness the slot ends straight from ON.
            if (r_sctr == SLOT_LAST) begin
              w_slot_end = 1'b1;
            end else if (r_sctr == r_blat) begin
              w_state_nx = ST_OFF;
            end
          end
        end
        ST_OFF: begin
          if (w_tick) begin
            w_sctr_nx = r_sctr + 4'd1;
            if (r_sctr == SLOT_LAST) begin
              w_slot_end = 1'b1;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
      if (w_slot_end) begin
        w_state_nx = ST_GUARD;
        w_sctr_nx  = '0;
        if (r_digit == DIG_LAST) begin
          w_digit_nx = '0;
          w_frame_nx = 1'b1;
        end else begin
          w_digit_nx = r_digit + DIG_ONE;
        end
      end
    end
  end

  // Anodes are built from next-cycle state and next-cycle register values, so
  // a MASK/CTRL write lands on an at the same edge as the register itself.
  always_comb begin
    w_an_nx = '1;
    if ((w_state_nx == ST_ON) && w_ctrl_nx[CTRL_RUN_BIT] &&
        !w_ctrl_nx[CTRL_BLANK_BIT] && w_mask_nx[w_digit_nx]) begin
      w_an_nx[w_digit_nx] = 1'b0;
    end
  end

  assign an    = r_an;
  assign digit = r_digit;
  assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] rdata;
  logic [3:0]  an;
  logic [1:0]  digit;
  logic        frame;

  seg7_scan_ctrl #(.BASE(16), .NDIGITS(4), .PRE_RST(16'h00FF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .rw      (rw),
    .addr    (addr),
    .data    (data),
    .rdata   (rdata),
    .an      (an),
    .digit   (digit),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int dig;
    int gap;
    int low;
    int lead;
    int msk;
  } slot_t;

  slot_t       slot_q[$];
  logic [31:0] rd_q[$];
  bit          mon_en = 1'b0;
  int          exp_frame_gap = 64;
  int          frames_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   prev_digit = 0;
  int   slot_clk = 0, slot_low = 0, slot_lead = -1, slot_mask = 0, slot_multi = 0;
  int   last_frame = -1;
  bit   rd_cap = 1'b0;
  logic [3:0] nan;

  always begin
    @(posedge clk);
    rd_cap = enable && !rw;
    @(negedge clk);
    cyc++;
    if (rd_cap) begin
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rdata 0x%0h with no read pending", rdata);
      end else begin
        chk("rdata", rdata, rd_q.pop_front());
      end
    end
    if (int'(digit) != prev_digit) begin
      if (mon_en) begin
        if (slot_q.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected: digit %0d with no slot expected", digit);
        end else begin
          slot_t e;
          e = slot_q.pop_front();
          chk("slot_digit", 32'(digit), e.dig);
          chk("slot_gap", slot_clk, e.gap);
          chk("slot_low_clks", slot_low, e.low);
          chk("slot_low_mask", slot_mask, e.msk);
          chk("slot_multi_low", slot_multi, 0);
          if (e.lead >= 0) chk("slot_guard_lead", slot_lead, e.lead);
        end
      end
      prev_digit = int'(digit);
      slot_clk = 0; slot_low = 0; slot_lead = -1; slot_mask = 0; slot_multi = 0;
    end
    slot_clk++;
    nan = ~an;
    if (nan != 4'h0) begin
      slot_low++;
      slot_mask |= int'(nan);
      if (slot_lead < 0) slot_lead = slot_clk - 1;
      if ($countones(nan) > 1) slot_multi = 1;
    end
    if (!mon_en) begin
      last_frame = -1;
    end else if (frame) begin
      frames_seen++;
      chk("frame_digit", 32'(digit), 0);
      if (last_frame >= 0) chk("frame_period", cyc - last_frame, exp_frame_gap);
      last_frame = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    enable = 1'b1; rw = 1'b1; addr = 32'(a); data = d;
    @(negedge clk);
    enable = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input int a, input logic [31:0] exp);
    @(negedge clk);
    rd_q.push_back(exp);
    enable = 1'b1; rw = 1'b0; addr = 32'(a);
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic sync_change(input int bound, output int d);
    int d0;
    bit seen;
    d0 = int'(digit);
    seen = 1'b0;
    d = d0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (int'(digit) != d0) begin
        seen = 1'b1;
        d = int'(digit);
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL sync_timeout: digit stuck at %0d for %0d clks", d0, bound);
    end
  endtask

  task automatic run_slots(input int n, input int bright, input logic [3:0] msk,
                           input bit blank, input int pre);
    int d, p, nd, nfr;
    bit on;
    slot_t e;
    #1 mon_en = 1'b0;
    sync_change(400, d);
    #1;
    exp_frame_gap = 64 * (pre + 1);
    nfr = 0;
    for (int k = 0; k < n; k++) begin
      p  = (d + k) % 4;
      nd = (p + 1) % 4;
      on = msk[p] && !blank && (bright > 0);
      e.dig  = nd;
      e.gap  = 16 * (pre + 1);
      e.low  = on ? bright * (pre + 1) : 0;
      e.lead = on ? pre + 1 : -1;
      e.msk  = on ? (1 << p) : 0;
      slot_q.push_back(e);
      if (nd == 0) nfr++;
    end
    frames_seen = 0;
    mon_en = 1'b1;
    for (int i = 0; i < n * 16 * (pre + 1) + 50; i++) begin
      @(negedge clk);
      if (slot_q.size() == 0) break;
    end
    #1;
    if (slot_q.size() != 0) begin
      errors++;
      $display("FAIL slot_timeout: %0d slots never seen", slot_q.size());
      slot_q.delete();
    end
    chk("frames_in_window", frames_seen, nfr);
    mon_en = 1'b0;
  endtask

  initial begin
    int  d;
    bit  found;
    reset_n = 1'b0; enable = 1'b0; rw = 1'b0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_rdata", rdata, 0);
    reset_n = 1'b1;

    // Register defaults, out-of-range reads, ignored out-of-range write.
    bus_read(16, 32'hFF);
    bus_read(17, 32'hF);
    bus_read(18, 32'hF);
    bus_read(19, 32'h1);
    bus_read(23, 32'h0);
    bus_read(15, 32'h0);
    bus_write(20, 32'h1234);
    bus_read(16, 32'hFF);

    // Fastest scan, full brightness.
    bus_write(16, 32'h0);
    run_slots(8, 15, 4'hF, 1'b0, 0);

    // Unused write bits dropped; BRIGHT=4 duty pattern.
    bus_write(17, 32'hFFFF_FFF4);
    bus_read(17, 32'h4);
    run_slots(4, 4, 4'hF, 1'b0, 0);

    // Masked digits keep their slot.
    bus_write(18, 32'hFFFF_FFFA);
    bus_read(18, 32'hA);
    run_slots(8, 4, 4'b1010, 1'b0, 0);

    // blank_all.
    bus_write(18, 32'hF);
    bus_write(19, 32'h3);
    run_slots(4, 4, 4'hF, 1'b1, 0);
    bus_write(19, 32'h1);

    // BRIGHT=0 goes straight to OFF.
    bus_write(17, 32'h0);
    run_slots(4, 0, 4'hF, 1'b0, 0);
    bus_write(17, 32'h4);

    // Clear run while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (digit == 2'd2 && an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    chk("digit2_lit_seen", 32'(found), 1);
    bus_write(19, 32'h0);
    chk("stop_an_off", 32'(an), 32'hF);
    @(negedge clk);
    chk("stop_digit0", 32'(digit), 0);
    repeat (30) @(negedge clk);
    chk("idle_an", 32'(an), 32'hF);
    chk("idle_digit", 32'(digit), 0);
    bus_write(19, 32'h1);
    sync_change(40, d);
    chk("restart_first_digit", d, 1);
    run_slots(4, 4, 4'hF, 1'b0, 0);

    // Slower prescale.
    bus_write(16, 32'h3);
    bus_read(16, 32'h3);
    bus_read(23, 32'h0);
    run_slots(4, 4, 4'hF, 1'b0, 3);

    // Asynchronous reset in the middle of a lit phase.
    bus_read(16, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an != 4'hF && digit != 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    chk("lit_before_reset", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_digit", 32'(digit), 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_frame", 32'(frame), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(16, 32'hFF);
    bus_read(17, 32'hF);
    bus_read(18, 32'hF);
    bus_read(19, 32'h1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
